// File: rtl/micro_seq_pkg.sv
// Shared definitions for the microprogram sequencer: opcode encoding and default sizes.
// The optional sticky stack-error port is enabled with MICRO_SEQ_STKERR_EN.
package micro_seq_pkg;

  localparam int AW_DEFAULT    = 10;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    JZ   = 3'd0,
    CJS  = 3'd1,
    JMAP = 3'd2,
    CJP  = 3'd3,
    PUSH = 3'd4,
    CRTN = 3'd5,
    RFCT = 3'd6,
    CONT = 3'd7
  } opcode_e;

endpackage

// File: rtl/micro_seq_stack.sv
// Subroutine/loop LIFO: DEPTH entries of AW bits, top-of-stack read, push/pop/clear.
// With MICRO_SEQ_STKERR_EN it also keeps a sticky overflow/underflow flag.
module micro_seq_stack
  import micro_seq_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          cp,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] tos,
  output logic          full
`ifdef MICRO_SEQ_STKERR_EN
  ,
  output logic          stk_err
`endif
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [AW-1:0]  stk_q [DEPTH];
  logic [AW-1:0]  stk_d [DEPTH];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_d;
  logic           empty;
  logic           ovf;
  logic           unf;

  assign full  = (sp_q == SP_FULL);
  assign empty = (sp_q == '0);

  // Top of stack is entry sp-1; an empty stack reads as zero.
  always_comb begin
    tos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (SPW'(i + 1) == sp_q) tos = stk_q[i];
    end
  end

  // A push at full overwrites the top entry; a pop at empty leaves sp at zero.
  always_comb begin
    stk_d = stk_q;
    sp_d  = sp_q;
    ovf   = 1'b0;
    unf   = 1'b0;
    if (clear) begin
      sp_d = '0;
    end else if (push) begin
      if (full) begin
        ovf = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          if (SPW'(i + 1) == sp_q) stk_d[i] = din;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (SPW'(i) == sp_q) stk_d[i] = din;
        end
        sp_d = sp_q + SPW'(1);
      end
    end else if (pop) begin
      if (empty) unf = 1'b1;
      else       sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      stk_q <= stk_d;
    end
  end

`ifdef MICRO_SEQ_STKERR_EN
  logic stk_err_q;
  logic stk_err_d;

  always_comb begin
    stk_err_d = stk_err_q | ovf | unf;
    if (clear) stk_err_d = 1'b0;
  end

  always_ff @(posedge cp or posedge rst) begin
    if (rst) stk_err_q <= 1'b0;
    else     stk_err_q <= stk_err_d;
  end

  assign stk_err = stk_err_q;
`else
  logic unused_err;
  assign unused_err = ovf | unf;
`endif

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: combinational next-address select over uPC, loop counter and LIFO.
// Define MICRO_SEQ_STKERR_EN to add the sticky stk_err output.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          cp,
  input  logic          rst,
  input  logic [2:0]    inst,
  input  logic          cc,
  input  logic          ccen,
  input  logic          cin,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] y,
  output logic          full,
  output logic          cnt_zero
`ifdef MICRO_SEQ_STKERR_EN
  ,
  output logic          stk_err
`endif
);

  opcode_e       op;
  logic          pass;
  logic [AW-1:0] upc_q;
  logic [AW-1:0] upc_d;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;
  logic [AW-1:0] tos;
  logic          push;
  logic          pop;
  logic          clear;
  logic          cnt_load;
  logic          cnt_dec;

  assign op       = opcode_e'(inst);
  assign pass     = ~ccen | cc;
  assign cnt_zero = (cnt_q == '0);

  // Next-address select and side-effect strobes; every effect lands on the same edge as uPC.
  always_comb begin
    y        = upc_q;
    push     = 1'b0;
    pop      = 1'b0;
    clear    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (op)
      JZ: begin
        y     = '0;
        clear = 1'b1;
      end
      CJS: begin
        if (pass) begin
          y    = d;
          push = 1'b1;
        end
      end
      JMAP: y = d;
      CJP: begin
        if (pass) y = d;
      end
      PUSH: begin
        push     = 1'b1;
        cnt_load = pass;
      end
      CRTN: begin
        if (pass) begin
          y   = tos;
          pop = 1'b1;
        end
      end
      RFCT: begin
        if (!cnt_zero) begin
          y       = tos;
          cnt_dec = 1'b1;
        end else begin
          pop = 1'b1;
        end
      end
      CONT: y = upc_q;
      default: y = upc_q;
    endcase
  end

  always_comb begin
    upc_d = y + AW'(cin);
    cnt_d = cnt_q;
    if (cnt_load)     cnt_d = d;
    else if (cnt_dec) cnt_d = cnt_q - AW'(1);
  end

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      upc_q <= '0;
      cnt_q <= '0;
    end else begin
      upc_q <= upc_d;
      cnt_q <= cnt_d;
    end
  end

  micro_seq_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .cp      (cp),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .din     (upc_q),
    .tos     (tos),
    .full    (full)
`ifdef MICRO_SEQ_STKERR_EN
    ,
    .stk_err (stk_err)
`endif
  );

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
- REQ-001 SHALL have parameter AW, default 10, the microaddress width in bits.
- REQ-002 SHALL have parameter DEPTH, default 4, the subroutine/loop stack depth in entries.
- REQ-003 SHALL have clock cp, one clock, rising edge; reset rst, asynchronous, active-high.
- REQ-004 SHALL have ports:
  - cp  input  1  clock
  - rst  input  1  async active-high reset
  - inst  input  3  sequencer opcode
  - cc  input  1  test condition, active-high
  - ccen  input  1  condition enable; 0 forces pass
  - cin  input  1  uPC increment enable
  - d  input  AW  branch, map or count data
  - y  output  AW  next microaddress, driven to microcode ROM
  - full  output  1  stack holds DEPTH entries
  - cnt_zero  output  1  loop counter equals 0
  - stk_err  output  1  sticky stack error, present only under REQ-019

Function
- REQ-005 SHALL define pass = ~ccen | cc.
- REQ-006 SHALL compute y combinationally from inst, pass, d and registers. The registers are uPC, counter (AW bits), stack and sp.
- REQ-007 SHALL, on every rising cp, load uPC <= y + cin, modulo 2^AW; y = 2^AW-1 with cin=1 SHALL wrap to 0.
- REQ-008 SHALL decode opcodes as follows (TOS = stack top, 0 when sp=0):
  - 0 JZ: y=0; clear sp.
  - 1 CJS: if pass, y=d and push uPC; else y=uPC.
  - 2 JMAP: y=d unconditionally.
  - 3 CJP: if pass, y=d; else y=uPC.
  - 4 PUSH: y=uPC; push uPC; if pass, load counter<=d.
  - 5 CRTN: if pass, y=TOS and pop; else y=uPC.
  - 6 RFCT: if counter!=0, y=TOS and counter<=counter-1; else y=uPC and pop.
  - 7 CONT: y=uPC.
- REQ-009 SHALL apply every push, pop and counter update on the same rising cp as the uPC update; each instruction has one-cycle latency.
- REQ-010 SHALL, on push when sp=DEPTH, overwrite TOS and leave sp unchanged.
- REQ-011 SHALL, on pop when sp=0, leave sp at 0 and use y=0 for the popped value.
- REQ-012 SHALL assert full when sp=DEPTH.
- REQ-013 SHALL assert cnt_zero when counter=0; the counter SHALL never decrement below 0.
- REQ-014 SHALL perform PUSH with pass as a single cycle: the push and the counter load take effect together.

Reset
- REQ-015 SHALL, while rst=1, hold uPC=0, counter=0, sp=0, every stack entry=0 and stk_err=0, independent of cp.
- REQ-016 SHALL, during reset, drive y per REQ-008 from the zeroed registers, with full=0 and cnt_zero=1.
- REQ-017 SHALL let reset asserted mid-loop or mid-subroutine discard all stack state.
- REQ-018 SHALL apply the first opcode on the first rising cp after rst deasserts.

Configuration
- REQ-019 SHALL add port stk_err and its logic only when macro MICRO_SEQ_STKERR_EN is defined.
  - stk_err is set on a push at full or a pop at empty.
  - stk_err is sticky and is cleared only by JZ or rst.
- REQ-020 SHALL, without MICRO_SEQ_STKERR_EN, omit the port; all other behaviour is identical.

Structure
- REQ-021 SHALL place in shared package micro_seq_pkg:
  - the opcode enum: JZ, CJS, JMAP, CJP, PUSH, CRTN, RFCT, CONT;
  - the default AW and DEPTH constants.
- REQ-022 SHALL implement the LIFO (entries, sp, full, push/pop/clear, TOS) as sub-module micro_seq_stack; the top level holds uPC, counter and decode.

Verification
- REQ-023 Reset, then CONT with cin=1 for 3 cycles -> y sequence 0, 1, 2, 3; cnt_zero=1.
- REQ-024 At uPC=5: CJS d=0x40 pass -> y=0x40; at 0x41 CRTN pass -> y=6; sp returns to 0.
- REQ-025 CJP d=0x80 with ccen=1, cc=0 -> y=uPC; with ccen=0 -> y=0x80.
- REQ-026 Loop: at uPC=0x10, PUSH d=2; body at 0x11 is RFCT.
  - Expected y sequence: 0x11, 0x11, 0x11, 0x12 (RFCT reached three times, first two with counter nonzero).
  - Expected counter sequence: 2, 1, 0; then the pop takes sp to 0.
- REQ-027 Push DEPTH+1 times -> full=1 from the DEPTH-th push, sp=DEPTH, TOS=last pushed value; with MICRO_SEQ_STKERR_EN, stk_err=1 until JZ.
- REQ-028 Assert rst mid-loop, between cp edges -> y, sp and counter read 0 immediately; CRTN after release -> y=0.
